// File: rtl/ser_pkg.sv
// ---------------------------------------------------------------------------
// ser_pkg
// Shared definitions for the frame serializer:
//   - ser_state_e       : serializer FSM states (IDLE, SHIFT, GAP)
//   - FRAME_W_DEF       : default frame length in bits
//   - CLKS_PER_BIT_DEF  : default clocks per serial bit
//   - START_BIT/STOP_BIT: required levels of frame bit 0 and bit FRAME_W-1
//   - framing_ok()      : start/stop bit check on a candidate frame
// ---------------------------------------------------------------------------
package ser_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } ser_state_e;

    localparam int   FRAME_W_DEF      = 10;
    localparam int   CLKS_PER_BIT_DEF = 868;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    function automatic logic framing_ok(input logic first_bit, input logic last_bit);
        return (first_bit == START_BIT) && (last_bit == STOP_BIT);
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// ---------------------------------------------------------------------------
// baud_tick_gen
// Restartable bit-time counter. Emits a one-cycle tick every CLKS_PER_BIT
// cycles. Asserting clear_i restarts the count so the first tick lands
// CLKS_PER_BIT cycles after the clearing edge.
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   synchronous active-high reset
//   clear_i in   restart the bit-time count on this edge
//   tick_o  out  high during the last cycle of each bit-time
// ---------------------------------------------------------------------------
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    output logic tick_o
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_cfg
        $error("baud_tick_gen: CLKS_PER_BIT must be >= 2");
    end

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Tick is combinational so the FSM acts on the edge that ends the bit.
    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/frame_serializer.sv
// ---------------------------------------------------------------------------
// frame_serializer
// Accepts one parallel frame on a valid/ready handshake and shifts it out on
// tx_o, bit 0 first, each bit held CLKS_PER_BIT clocks, followed by GAP_BITS
// idle bit-times. Frames with a bad start/stop bit are rejected when
// CHECK_FRAMING is set.
//
// Handshake: a frame is taken on any rising edge where frame_valid and
// frame_ready are both high; frame_i is sampled only on that edge. The source
// holds frame_valid (and frame_i) until it sees the handshake complete.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   frame_i      in   parallel frame, bit 0 transmitted first
//   frame_valid  in   frame_i is valid
//   frame_ready  out  frame can be accepted this cycle (IDLE and not in reset)
//   tx_o         out  serial line
//   busy         out  high in SHIFT or GAP
//   done         out  one-cycle pulse when the line is released after a frame
//   frame_err    out  one-cycle pulse after a frame is rejected for framing
//   state_o      out  current FSM state (ser_state_e encoding), for debug
// ---------------------------------------------------------------------------
module frame_serializer
    import ser_pkg::*;
#(
    parameter int   FRAME_W       = FRAME_W_DEF,
    parameter int   CLKS_PER_BIT  = CLKS_PER_BIT_DEF,
    parameter int   GAP_BITS      = 1,
    parameter logic IDLE_LEVEL    = 1'b1,
    parameter int   CHECK_FRAMING = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FRAME_W-1:0] frame_i,
    input  logic               frame_valid,
    output logic               frame_ready,
    output logic               tx_o,
    output logic               busy,
    output logic               done,
    output logic               frame_err,
    output logic [1:0]         state_o
);

    localparam int BW = $clog2(FRAME_W + 1);
    // Keep the gap counter at least one bit wide even when GAP_BITS is 0.
    localparam int GW = (GAP_BITS > 0) ? $clog2(GAP_BITS + 1) : 1;

    ser_state_e       state_q, state_d;
    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic tick;
    logic accept;
    logic frame_good;
    logic start;
    logic last_bit;
    logic last_gap;

    assign frame_ready = (state_q == IDLE) && !rst;
    assign accept      = frame_valid && frame_ready;
    assign frame_good  = (CHECK_FRAMING == 0) ||
                         framing_ok(frame_i[0], frame_i[FRAME_W-1]);
    assign start       = accept && frame_good;
    assign last_bit    = (bit_cnt_q == BW'(FRAME_W - 1));
    assign last_gap    = (gap_cnt_q == GW'(GAP_BITS - 1));

    // Cleared on the acceptance edge so bit 0 occupies exactly the next
    // CLKS_PER_BIT cycles.
    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .clear_i(start),
        .tick_o (tick)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (tick && last_bit) begin
                    state_d = (GAP_BITS == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (tick && last_gap) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: line level, busy, and the next values of the pulses.
    always_comb begin
        tx_o    = IDLE_LEVEL;
        busy    = 1'b0;
        done_d  = 1'b0;
        err_d   = accept && !frame_good;
        case (state_q)
            SHIFT: begin
                tx_o   = shreg_q[0];
                busy   = 1'b1;
                done_d = tick && last_bit && (GAP_BITS == 0);
            end
            GAP: begin
                busy   = 1'b1;
                done_d = tick && last_gap;
            end
            default: begin
                tx_o = IDLE_LEVEL;
            end
        endcase
    end

    // Datapath next-state: shift register and bit/gap counters.
    always_comb begin
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        if (start) begin
            shreg_d   = frame_i;
            bit_cnt_d = '0;
            gap_cnt_d = '0;
        end else if (tick && (state_q == SHIFT)) begin
            shreg_d   = {IDLE_LEVEL, shreg_q[FRAME_W-1:1]};
            bit_cnt_d = bit_cnt_q + BW'(1);
        end else if (tick && (state_q == GAP)) begin
            gap_cnt_d = gap_cnt_q + GW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign done      = done_q;
    assign frame_err = err_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_frame_serializer.sv
// ---------------------------------------------------------------------------
// tb_frame_serializer
// Bench for frame_serializer with CLKS_PER_BIT=4, GAP_BITS=1, FRAME_W=10,
// CHECK_FRAMING=1. A cycle-count reference model predicts every output each
// cycle; accepted frames are also pushed to a scoreboard queue and compared
// against the bits recovered from tx_o when done pulses.
// ---------------------------------------------------------------------------
module tb_frame_serializer;
    import ser_pkg::*;

    localparam int FW  = 10;
    localparam int C   = 4;
    localparam int GB  = 1;
    localparam int TOT = (FW + GB) * C;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_valid = 1'b0;
    logic [FW-1:0] frame_i = '0;
    logic          frame_ready;
    logic          tx_o;
    logic          busy;
    logic          done;
    logic          frame_err;
    logic [1:0]    state_o;

    always #5 clk = ~clk;

    frame_serializer #(
        .FRAME_W      (FW),
        .CLKS_PER_BIT (C),
        .GAP_BITS     (GB),
        .IDLE_LEVEL   (1'b1),
        .CHECK_FRAMING(1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_i    (frame_i),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .tx_o       (tx_o),
        .busy       (busy),
        .done       (done),
        .frame_err  (frame_err),
        .state_o    (state_o)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Timeline view: a good frame accepted at the edge ending cycle A drives
    // bit k during cycles A+k*C+1 .. A+(k+1)*C, idles through A+TOT, and
    // pulses done in cycle A+TOT+1.
    int            acc_cyc    = -1000;
    bit            m_active   = 1'b0;
    int            err_cyc    = -1;
    logic [FW-1:0] m_frame    = '0;
    bit            m_accepted = 1'b0;
    logic [FW-1:0] exp_q[$];

    function automatic bit exp_busy();
        int d = cyc - acc_cyc;
        return m_active && (d >= 1) && (d <= TOT);
    endfunction

    function automatic logic exp_tx();
        int d = cyc - acc_cyc;
        if (m_active && (d >= 1) && (d <= FW * C)) return m_frame[(d - 1) / C];
        return 1'b1;
    endfunction

    function automatic logic exp_done();
        return m_active && ((cyc - acc_cyc) == TOT + 1);
    endfunction

    function automatic logic [1:0] exp_state();
        if (!exp_busy()) return IDLE;
        if ((cyc - acc_cyc) <= FW * C) return SHIFT;
        return GAP;
    endfunction

    always @(posedge clk) begin
        m_accepted = 1'b0;
        if (rst) begin
            if (exp_busy() && exp_q.size() > 0) void'(exp_q.pop_back());
            m_active = 1'b0;
        end else if (frame_valid && !exp_busy()) begin
            m_accepted = 1'b1;
            if (frame_i[0] == 1'b0 && frame_i[FW-1] == 1'b1) begin
                m_active = 1'b1;
                acc_cyc  = cyc;
                m_frame  = frame_i;
                exp_q.push_back(frame_i);
            end else begin
                err_cyc = cyc + 1;
            end
        end
        cyc++;
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            chk("tx_o",        {31'b0, tx_o},        {31'b0, exp_tx()});
            chk("busy",        {31'b0, busy},        {31'b0, exp_busy()});
            chk("done",        {31'b0, done},        {31'b0, exp_done()});
            chk("frame_err",   {31'b0, frame_err},   {31'b0, (cyc == err_cyc)});
            chk("frame_ready", {31'b0, frame_ready}, {31'b0, (!rst && !exp_busy())});
            chk("state",       {30'b0, state_o},     {30'b0, exp_state()});
        end
    end

    // ---------------- scoreboard monitor ----------------
    logic samples[$];

    always @(negedge clk) begin
        logic [FW-1:0] got_f;
        logic [FW-1:0] exp_f;
        int            idx;
        if (cyc >= 1) begin
            if (busy === 1'b1) samples.push_back(tx_o);
            if (done === 1'b1) begin
                chk("sb_has_frame", {31'b0, (exp_q.size() > 0)}, 32'd1);
                if (exp_q.size() > 0) begin
                    exp_f = exp_q.pop_front();
                    for (int k = 0; k < FW; k++) begin
                        idx = k * C + C / 2;
                        got_f[k] = (idx < samples.size()) ? samples[idx] : 1'bx;
                    end
                    chk("sb_len", samples.size(), TOT);
                    chk("sb_frame", {22'b0, got_f}, {22'b0, exp_f});
                end
                samples.delete();
            end
            if (rst === 1'b1) samples.delete();
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents f until the handshake edge; keep leaves frame_valid high.
    task automatic send_frame(input logic [FW-1:0] f, input bit keep);
        int n = 0;
        frame_valid = 1'b1;
        frame_i     = f;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!m_accepted && n < 200);
        chk("accept_wait", {31'b0, m_accepted}, 32'd1);
        if (!keep) frame_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [FW-1:0] f;
        bit            keep;

        // Reset held for three edges.
        idle(3);
        rst = 1'b0;
        idle(1);

        // Single good frame.
        send_frame(10'h2A6, 1'b0);
        idle(50);

        // Framing rejects: bad start bit, then bad stop bit.
        send_frame(10'h2A7, 1'b0);
        idle(5);
        send_frame(10'h0A6, 1'b0);
        idle(5);

        // Back-to-back with frame_valid held high.
        send_frame(10'h2A6, 1'b1);
        send_frame(10'h3FE, 1'b0);
        idle(50);

        // Input changes while busy are ignored.
        send_frame(10'h2A6, 1'b0);
        idle(4);
        frame_valid = 1'b1;
        frame_i     = 10'h000;
        idle(16);
        frame_valid = 1'b0;
        idle(30);

        // Reset in the middle of a frame, then a normal frame.
        send_frame(10'h2A6, 1'b0);
        idle(16);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        send_frame(10'h3A2, 1'b0);
        idle(50);

        // Randomized frames, gaps, back-to-back and occasional resets.
        for (int i = 0; i < 40; i++) begin
            f = FW'($urandom);
            if ($urandom_range(0, 4) != 0) begin
                f[0]    = 1'b0;
                f[FW-1] = 1'b1;
            end
            keep = ($urandom_range(0, 2) == 0);
            send_frame(f, keep);
            if ($urandom_range(0, 9) == 0) begin
                frame_valid = 1'b0;
                idle($urandom_range(1, 46));
                rst = 1'b1;
                idle(1);
                rst = 1'b0;
            end else if (!keep) begin
                idle($urandom_range(0, 50));
            end
        end

        frame_valid = 1'b0;
        idle(60);
        chk("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
